capsense_touch_detector: RTL

- Downstream consumer of the capacitive sensor's latched discharge count; one instance per mole pad.
- Builds a no-touch baseline from the first samples, then classifies each new count as touched or untouched using press/release thresholds with hysteresis and consecutive-sample debounce.
- Emits a touched level and one-cycle press/release pulses to the game logic, and flags a sensor fault when samples stop arriving.

---
 rtl/capsense_pkg.sv | 27 ++
 rtl/capsense_baseline_avg.sv | 51 +++++
 rtl/capsense_touch_detector.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/capsense_pkg.sv
// ============================================================================
// Module      : capsense_pkg
// Description : Shared types and default thresholds for the capsense touch path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package capsense_pkg;

  typedef enum logic [1:0] {
    CAL     = 2'd0,
    IDLE    = 2'd1,
    TOUCHED = 2'd2
  } cs_state_t;

  localparam int DEB_W = 4;

  localparam int DEF_COUNT_W        = 32;
  localparam int DEF_CAL_SHIFT      = 3;
  localparam int DEF_PRESS_DELTA    = 200;
  localparam int DEF_HYST           = 50;
  localparam int DEF_DEBOUNCE_N     = 3;
  localparam int DEF_TIMEOUT_CYCLES = 1000000;

endpackage

`default_nettype wire

// File: rtl/capsense_baseline_avg.sv
// ============================================================================
// Module      : capsense_baseline_avg
// Description : Averages 2^CAL_SHIFT samples; strobes done with the mean.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module capsense_baseline_avg
  import capsense_pkg::*;
#(
  parameter int COUNT_W   = DEF_COUNT_W,
  parameter int CAL_SHIFT = DEF_CAL_SHIFT
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               clear,
  input  logic               valid,
  input  logic [COUNT_W-1:0] count,
  output logic               done,
  output logic [COUNT_W-1:0] avg
);

  localparam int ACC_W = COUNT_W + CAL_SHIFT;
  localparam int CNT_W = CAL_SHIFT + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << CAL_SHIFT) - 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] n;

  // The done strobe carries the sum including the sample arriving this cycle.
  assign sum  = acc + ACC_W'(count);
  assign done = valid && !clear && (n == LAST);
  assign avg  = COUNT_W'(sum >> CAL_SHIFT);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc <= '0;
      n   <= '0;
    end else if (clear || done) begin
      acc <= '0;
      n   <= '0;
    end else if (valid) begin
      acc <= sum;
      n   <= n + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/capsense_touch_detector.sv
// ============================================================================
// Module      : capsense_touch_detector
// Description : Baseline calibration, hysteretic debounced touch detection
//               and sample-timeout fault for one capacitive pad.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module capsense_touch_detector
  import capsense_pkg::*;
#(
  parameter int COUNT_W        = DEF_COUNT_W,
  parameter int CAL_SHIFT      = DEF_CAL_SHIFT,
  parameter int PRESS_DELTA    = DEF_PRESS_DELTA,
  parameter int HYST           = DEF_HYST,
  parameter int DEBOUNCE_N     = DEF_DEBOUNCE_N,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               sample_valid,
  input  logic [COUNT_W-1:0] sample_count,
  input  logic               recalibrate,
  output logic               calibrated,
  output logic [COUNT_W-1:0] baseline,
  output logic               touched,
  output logic               press_pulse,
  output logic               release_pulse,
  output logic               sensor_fault
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_N - 1);

  cs_state_t        state;
  logic [DEB_W-1:0] deb;
  logic [TO_W-1:0]  to_cnt;

  logic               sample_ok;
  logic [COUNT_W:0]   press_thr;
  logic [COUNT_W:0]   rel_thr;
  logic               hot;
  logic               cold;
  logic               avg_done;
  logic [COUNT_W-1:0] avg_value;

  assign sample_ok = sample_valid && (sample_count != '0);
  assign press_thr = {1'b0, baseline} + (COUNT_W+1)'(PRESS_DELTA);
  assign rel_thr   = press_thr - (COUNT_W+1)'(HYST);
  assign hot       = {1'b0, sample_count} >= press_thr;
  assign cold      = {1'b0, sample_count} <  rel_thr;

  capsense_baseline_avg #(
    .COUNT_W   (COUNT_W),
    .CAL_SHIFT (CAL_SHIFT)
  ) u_avg (
    .clock  (clock),
    .resetn (resetn),
    .clear  (recalibrate),
    .valid  (sample_ok && (state == CAL)),
    .count  (sample_count),
    .done   (avg_done),
    .avg    (avg_value)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= CAL;
      deb           <= '0;
      calibrated    <= 1'b0;
      baseline      <= '0;
      touched       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else if (recalibrate) begin
      // Old baseline stays visible until calibration writes a new one.
      state         <= CAL;
      deb           <= '0;
      calibrated    <= 1'b0;
      touched       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= touched;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        CAL: begin
          if (avg_done) begin
            baseline   <= avg_value;
            calibrated <= 1'b1;
            state      <= IDLE;
          end
        end
        IDLE: begin
          if (sample_ok) begin
            if (!hot) begin
              deb <= '0;
            end else if (deb == DEB_LAST) begin
              deb         <= '0;
              state       <= TOUCHED;
              touched     <= 1'b1;
              press_pulse <= 1'b1;
            end else begin
              deb <= deb + DEB_W'(1);
            end
          end
        end
        TOUCHED: begin
          if (sample_ok) begin
            if (!cold) begin
              deb <= '0;
            end else if (deb == DEB_LAST) begin
              deb           <= '0;
              state         <= IDLE;
              touched       <= 1'b0;
              release_pulse <= 1'b1;
            end else begin
              deb <= deb + DEB_W'(1);
            end
          end
        end
        default: begin
          state <= CAL;
          deb   <= '0;
        end
      endcase
    end
  end

  // Zero counts are treated as no sample at all, so they do not feed the watchdog.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      to_cnt       <= '0;
      sensor_fault <= 1'b0;
    end else if (sample_ok) begin
      to_cnt       <= '0;
      sensor_fault <= 1'b0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + TO_W'(1);
      if (to_cnt == TO_MAX - TO_W'(1)) begin
        sensor_fault <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
